// File: rtl/bs_iter_sequencer.sv
// bs_iter_sequencer
//   Issue/retire sequencer for a fixed-latency Black-Scholes datapath.
//   It launches up to niter Gaussian samples (one per grn_valid) into a
//   LATENCY-deep pipeline. It tracks every in-flight sample with a token
//   delay line and accumulates the present value and its square as each
//   result retires.
//
// Ports
//   clk, nreset      clock, async active-low reset
//   niter            samples to issue (captured while IDLE)
//   cmd              command code (0 = no-op, CMD_RUN / CMD_ACK / CMD_ABORT)
//   grn_valid        random number available this cycle
//   pv_din, pow_din  datapath results, valid on the retire cycle
//   issue            launch / grn consume strobe (combinational)
//   status           0 IDLE, 1 RUNNING, 2 COMPLETE, 3 DRAIN
//   inflight         issued but not yet retired samples
//   sum_dout         running sum of pv_din
//   pow_sum_dout     running sum of pow_din
//   ovf              sticky carry-out of either accumulator
//   retired          number of results accumulated
module bs_iter_sequencer #(
    parameter int unsigned LATENCY   = 50,
    parameter int unsigned CMD_RUN   = 1,
    parameter int unsigned CMD_ACK   = 2,
    parameter int unsigned CMD_ABORT = 3
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic [31:0] niter,
    input  logic [3:0]  cmd,
    input  logic        grn_valid,
    input  logic [63:0] pv_din,
    input  logic [63:0] pow_din,
    output logic        issue,
    output logic [3:0]  status,
    output logic [6:0]  inflight,
    output logic [63:0] sum_dout,
    output logic [63:0] pow_sum_dout,
    output logic        ovf,
    output logic [31:0] retired
);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        RUNNING  = 4'd1,
        COMPLETE = 4'd2,
        DRAIN    = 4'd3
    } state_t;

    localparam logic [3:0] C_RUN   = CMD_RUN[3:0];
    localparam logic [3:0] C_ACK   = CMD_ACK[3:0];
    localparam logic [3:0] C_ABORT = CMD_ABORT[3:0];

    state_t              state;
    logic [31:0]         s_niter;
    logic [31:0]         issued_cnt;
    logic [LATENCY-1:0]  vld_pipe;   // bit k: a token has spent k+1 edges in flight
    logic [LATENCY:0]    vld_nxt;
    logic                abort;
    logic                retire;
    logic [64:0]         sum_add;
    logic [64:0]         pow_add;

    assign status = state;
    assign abort  = (state == RUNNING || state == DRAIN) && (cmd == C_ABORT);
    assign issue  = (state == RUNNING) && grn_valid && (issued_cnt < s_niter) && !abort;

    // A token in the last stage retires on the coming edge; an abort on
    // that same edge discards it with the rest of the pipeline.
    assign retire = vld_pipe[LATENCY-1] && !abort;

    // Concatenate first so the shift also works for LATENCY == 1.
    assign vld_nxt = {vld_pipe, issue};

    assign sum_add = {1'b0, sum_dout}     + {1'b0, pv_din};
    assign pow_add = {1'b0, pow_sum_dout} + {1'b0, pow_din};

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state        <= IDLE;
            s_niter      <= '0;
            issued_cnt   <= '0;
            vld_pipe     <= '0;
            inflight     <= '0;
            sum_dout     <= '0;
            pow_sum_dout <= '0;
            ovf          <= 1'b0;
            retired      <= '0;
        end else begin
            vld_pipe <= abort ? '0 : vld_nxt[LATENCY-1:0];

            if (retire) begin
                sum_dout     <= sum_add[63:0];
                pow_sum_dout <= pow_add[63:0];
                retired      <= retired + 32'd1;
                if (sum_add[64] || pow_add[64])
                    ovf <= 1'b1;
            end

            // issue and retire together leave the count unchanged
            if (issue && !retire)
                inflight <= inflight + 7'd1;
            else if (!issue && retire)
                inflight <= inflight - 7'd1;

            if (issue)
                issued_cnt <= issued_cnt + 32'd1;

            case (state)
                IDLE: begin
                    s_niter <= niter;
                    if (cmd == C_RUN) begin
                        sum_dout     <= '0;
                        pow_sum_dout <= '0;
                        retired      <= '0;
                        ovf          <= 1'b0;
                        issued_cnt   <= '0;
                        state        <= (niter != 32'd0) ? RUNNING : COMPLETE;
                    end
                end
                RUNNING: begin
                    if (abort) begin
                        issued_cnt <= '0;
                        inflight   <= '0;
                        state      <= IDLE;
                    end else if (issued_cnt >= s_niter) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (abort) begin
                        issued_cnt <= '0;
                        inflight   <= '0;
                        state      <= IDLE;
                    end else if (inflight == 7'd0 && !(|vld_pipe)) begin
                        state <= COMPLETE;
                    end
                end
                COMPLETE: begin
                    if (cmd == C_ACK)
                        state <= IDLE;
                end
                default: begin
                    issued_cnt <= '0;
                    inflight   <= '0;
                    vld_pipe   <= '0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bs_iter_sequencer.sv
// tb_bs_iter_sequencer
//   Directed bench for bs_iter_sequencer with LATENCY=4. A negedge monitor
//   pairs every issue with its retire and checks the fixed latency and the
//   one-cycle gap between the last retire and COMPLETE.
module tb_bs_iter_sequencer;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        nreset = 1'b1;
    logic [31:0] niter = '0;
    logic [3:0]  cmd = '0;
    logic        grn_valid = 1'b0;
    logic [63:0] pv_din = '0;
    logic [63:0] pow_din = '0;
    logic        issue;
    logic [3:0]  status;
    logic [6:0]  inflight;
    logic [63:0] sum_dout;
    logic [63:0] pow_sum_dout;
    logic        ovf;
    logic [31:0] retired;

    bs_iter_sequencer #(.LATENCY(LAT)) dut (
        .clk(clk), .nreset(nreset), .niter(niter), .cmd(cmd),
        .grn_valid(grn_valid), .pv_din(pv_din), .pow_din(pow_din),
        .issue(issue), .status(status), .inflight(inflight),
        .sum_dout(sum_dout), .pow_sum_dout(pow_sum_dout),
        .ovf(ovf), .retired(retired)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          ecnt = 0;
    int          n_iss = 0;
    int          last_ret_edge = -1;
    int          cmp_edge = -1;
    logic [31:0] ret_last = '0;
    logic [3:0]  st_last = '0;
    int          iss_q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_status(input logic [3:0] s, input int budget, input string tag);
        for (int i = 0; i < budget && status != s; i++) step();
        chk(tag, {60'd0, status}, {60'd0, s});
    endtask

    always @(posedge clk) ecnt++;

    // At a negedge, issue refers to the coming edge (ecnt+1); register
    // changes seen here happened on edge ecnt.
    always @(negedge clk) begin
        if (issue) begin
            iss_q.push_back(ecnt + 1);
            n_iss++;
        end
        if (retired == ret_last + 32'd1) begin
            last_ret_edge = ecnt;
            chk("ret_has_issue", iss_q.size() > 0, 1);
            if (iss_q.size() > 0) chk("ret_lat", ecnt, iss_q.pop_front() + LAT);
        end
        if (status == 4'd2 && st_last != 4'd2) cmp_edge = ecnt;
        ret_last = retired;
        st_last  = status;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // reset state
        #2 nreset = 1'b0;
        #1;
        chk("rst_status", status, 0);
        chk("rst_issue", issue, 0);
        chk("rst_inflight", inflight, 0);
        chk("rst_sum", sum_dout, 0);
        chk("rst_pow", pow_sum_dout, 0);
        chk("rst_retired", retired, 0);
        chk("rst_ovf", ovf, 0);
        repeat (2) @(posedge clk);
        #1 nreset = 1'b1;
        step();

        // basic run: niter=3, continuous grn_valid
        n_iss = 0;
        niter = 3; pv_din = 64'h1000; pow_din = 64'h2000; grn_valid = 1'b1; cmd = 4'd1;
        step();
        cmd = 4'd0;
        #1;
        chk("t1_run", status, 1);
        chk("t1_iss0", issue, 1);
        step(); chk("t1_iss1", issue, 1);
        step(); chk("t1_iss2", issue, 1);
        step(); chk("t1_iss3", issue, 0);
        chk("t1_infl", inflight, 3);
        wait_status(4'd3, 10, "t1_drain");
        wait_status(4'd2, 20, "t1_cmpl");
        @(negedge clk); #1;
        chk("t1_sum", sum_dout, 64'h3000);
        chk("t1_pow", pow_sum_dout, 64'h6000);
        chk("t1_ret", retired, 3);
        chk("t1_niss", n_iss, 3);
        chk("t1_cmpl_lat", cmp_edge, last_ret_edge + 1);
        step(); step();
        chk("t1_hold_st", status, 2);
        chk("t1_hold_sum", sum_dout, 64'h3000);

        // ACK, then niter=0
        cmd = 4'd2; step(); cmd = 4'd0;
        chk("t2_idle", status, 0);
        chk("t2_keep_sum", sum_dout, 64'h3000);
        n_iss = 0;
        niter = 0; cmd = 4'd1; step(); cmd = 4'd0; #1;
        chk("t2_cmpl", status, 2);
        chk("t2_sum", sum_dout, 0);
        chk("t2_ret", retired, 0);
        chk("t2_iss", issue, 0);
        step();
        chk("t2_niss", n_iss, 0);
        cmd = 4'd2; step(); cmd = 4'd0;
        chk("t2_ack", status, 0);

        // toggling grn_valid, niter=5
        n_iss = 0;
        niter = 5; pv_din = 64'h10; pow_din = 64'h1; grn_valid = 1'b0; cmd = 4'd1;
        step();
        cmd = 4'd0;
        for (int i = 0; i < 14; i++) begin
            grn_valid = (i % 2 == 0);
            #1;
            if (!grn_valid) chk("t3_lo", issue, 0);
            step();
        end
        grn_valid = 1'b0;
        wait_status(4'd2, 20, "t3_cmpl");
        chk("t3_niss", n_iss, 5);
        chk("t3_ret", retired, 5);
        chk("t3_sum", sum_dout, 64'h50);
        chk("t3_pow", pow_sum_dout, 64'h5);
        cmd = 4'd2; step(); cmd = 4'd0;

        // accumulator wrap and sticky ovf
        niter = 2; pv_din = 64'hFFFF_FFFF_FFFF_F000; pow_din = 64'h0; grn_valid = 1'b1; cmd = 4'd1;
        step();
        cmd = 4'd0;
        chk("t4_ovf0", ovf, 0);
        wait_status(4'd2, 30, "t4_cmpl");
        chk("t4_sum", sum_dout, 64'hFFFF_FFFF_FFFF_E000);
        chk("t4_ovf", ovf, 1);
        cmd = 4'd2; step(); cmd = 4'd0;
        chk("t4_ovf_idle", ovf, 1);
        niter = 0; cmd = 4'd1; step(); cmd = 4'd0;
        chk("t4_ovf_clr", ovf, 0);
        cmd = 4'd2; step(); cmd = 4'd0;

        // abort at inflight=3
        niter = 10; pv_din = 64'h100; grn_valid = 1'b1; cmd = 4'd1;
        step();
        cmd = 4'd0;
        for (int i = 0; i < 10 && inflight != 7'd3; i++) step();
        chk("t5_infl3", inflight, 3);
        cmd = 4'd3; #1;
        chk("t5_iss_abort", issue, 0);
        step();
        cmd = 4'd0;
        iss_q.delete();
        chk("t5_idle", status, 0);
        chk("t5_infl0", inflight, 0);
        chk("t5_iss_idle", issue, 0);
        repeat (8) step();
        chk("t5_ret", retired, 0);
        chk("t5_sum", sum_dout, 0);
        chk("t5_infl_end", inflight, 0);

        // async reset mid-DRAIN
        niter = 3; pv_din = 64'h1000; pow_din = 64'h2000; grn_valid = 1'b1; cmd = 4'd1;
        step();
        cmd = 4'd0;
        for (int i = 0; i < 20 && !(status == 4'd3 && retired >= 32'd1); i++) step();
        chk("t6_pre_drain", status, 3);
        chk("t6_pre_sum", sum_dout, 64'h1000);
        #2 nreset = 1'b0;
        #1;
        iss_q.delete();
        chk("t6_status", status, 0);
        chk("t6_issue", issue, 0);
        chk("t6_infl", inflight, 0);
        chk("t6_sum", sum_dout, 0);
        chk("t6_pow", pow_sum_dout, 0);
        chk("t6_ret", retired, 0);
        chk("t6_ovf", ovf, 0);
        @(posedge clk);
        #1 nreset = 1'b1;
        step();
        chk("t6_wait_idle", status, 0);
        niter = 1; cmd = 4'd1; step(); cmd = 4'd0;
        wait_status(4'd2, 20, "t6_cmpl");
        chk("t6_ret_after", retired, 1);
        chk("t6_sum_after", sum_dout, 64'h1000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
